// File: rtl/sram_uart_tx_interface.sv
// Streams a block of 16-bit SRAM words out of an 8N1 UART transmitter, high byte first.
// The next word is prefetched from SRAM while the low byte of the current word is on the line.
`timescale 1ns/1ps
module sram_uart_tx_interface #(
    parameter int BAUD_DIVIDER = 434
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [17:0] i_base_address,
    input  logic [17:0] i_word_count,
    output logic [17:0] o_sram_address,
    input  logic [15:0] i_sram_read_data,
    output logic        o_sram_we_n,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int BAUD_W = (BAUD_DIVIDER > 1) ? $clog2(BAUD_DIVIDER) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIVIDER - 1);
    // SRAM data for the prefetched address is valid on the third edge after SEND_LO entry
    localparam logic [BAUD_W-1:0] PREFETCH_SLOT = BAUD_W'(2);

    typedef enum logic [2:0] {
        S_TX_IDLE,
        S_TX_READ,
        S_TX_WAIT,
        S_TX_CAPTURE,
        S_TX_SEND_HI,
        S_TX_SEND_LO,
        S_TX_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [3:0]          r_bit_cnt;
    logic                r_tx;
    logic [15:0]         r_word;
    logic [15:0]         r_prefetch;
    logic [17:0]         r_words_left;
    logic [17:0]         r_sram_address;

    logic                w_slot_end;
    logic                w_byte_end;
    logic                w_more_words;
    logic                w_sending;
    logic [7:0]          w_cur_byte;
    logic                w_next_slot_bit;

    assign w_sending    = (r_state == S_TX_SEND_HI) || (r_state == S_TX_SEND_LO);
    assign w_slot_end   = (r_baud_cnt == BAUD_LAST);
    assign w_byte_end   = w_slot_end && (r_bit_cnt == 4'd9);
    assign w_more_words = (r_words_left > 18'd1);

    // Line level for the slot that follows the current one: data bits LSB first, then stop
    always_comb begin
        w_cur_byte = (r_state == S_TX_SEND_LO) ? r_word[7:0] : r_word[15:8];
        if (r_bit_cnt == 4'd8) begin
            w_next_slot_bit = 1'b1;
        end else begin
            w_next_slot_bit = w_cur_byte[r_bit_cnt[2:0]];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_TX_IDLE: begin
                if (i_start) begin
                    w_next_state = (i_word_count != 18'd0) ? S_TX_READ : S_TX_DONE;
                end
            end
            S_TX_READ:    w_next_state = S_TX_WAIT;
            S_TX_WAIT:    w_next_state = S_TX_CAPTURE;
            S_TX_CAPTURE: w_next_state = S_TX_SEND_HI;
            S_TX_SEND_HI: begin
                if (w_byte_end) begin
                    w_next_state = S_TX_SEND_LO;
                end
            end
            S_TX_SEND_LO: begin
                if (w_byte_end) begin
                    w_next_state = w_more_words ? S_TX_SEND_HI : S_TX_DONE;
                end
            end
            S_TX_DONE:    w_next_state = S_TX_IDLE;
            default:      w_next_state = S_TX_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (r_state != S_TX_IDLE) && (r_state != S_TX_DONE);
        o_done         = (r_state == S_TX_DONE);
        o_sram_we_n    = 1'b1;
        o_uart_tx      = r_tx;
        o_sram_address = r_sram_address;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_baud_cnt     <= '0;
            r_bit_cnt      <= 4'd0;
            r_tx           <= 1'b1;
            r_word         <= 16'd0;
            r_prefetch     <= 16'd0;
            r_words_left   <= 18'd0;
            r_sram_address <= 18'd0;
        end else begin
            case (r_state)
                S_TX_IDLE: begin
                    if (i_start && (i_word_count != 18'd0)) begin
                        r_words_left   <= i_word_count;
                        r_sram_address <= i_base_address;
                    end
                end
                S_TX_CAPTURE: begin
                    r_word     <= i_sram_read_data;
                    r_tx       <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_cnt  <= 4'd0;
                end
                default: ;
            endcase

            if (w_sending) begin
                if (w_slot_end) begin
                    r_baud_cnt <= '0;
                    if (r_bit_cnt == 4'd9) begin
                        r_bit_cnt <= 4'd0;
                        if (r_state == S_TX_SEND_HI) begin
                            r_tx <= 1'b0;
                            if (w_more_words) begin
                                r_sram_address <= r_sram_address + 18'd1;
                            end
                        end else if (w_more_words) begin
                            r_word       <= r_prefetch;
                            r_tx         <= 1'b0;
                            r_words_left <= r_words_left - 18'd1;
                        end else begin
                            r_tx <= 1'b1;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        r_tx      <= w_next_slot_bit;
                    end
                end else begin
                    r_baud_cnt <= r_baud_cnt + 1'b1;
                end
            end

            if ((r_state == S_TX_SEND_LO) && (r_bit_cnt == 4'd0) && (r_baud_cnt == PREFETCH_SLOT)) begin
                r_prefetch <= i_sram_read_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_uart_tx_interface.sv
// Directed testbench for sram_uart_tx_interface with a 2-cycle-latency SRAM model
// and per-cycle capture of the UART line, Busy, Done and SRAM address.
`timescale 1ns/1ps
module tb_sram_uart_tx_interface;

    localparam int BAUD = 4;
    localparam int LOG_DEPTH = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [17:0] baseAddress = 18'd0;
    logic [17:0] wordCount = 18'd0;
    logic [17:0] sramAddress;
    logic [15:0] sramReadData;
    logic        sramWeN;
    logic        uartTx;
    logic        busy;
    logic        done;

    int testsRun = 0;
    int testsFailed = 0;

    logic [15:0] sramMem [0:262143];
    logic [15:0] sramPipe1 = 16'd0;
    logic [15:0] sramPipe2 = 16'd0;

    logic        lineLog [0:LOG_DEPTH-1];
    logic        doneLog [0:LOG_DEPTH-1];
    logic        busyLog [0:LOG_DEPTH-1];
    logic [17:0] addrLog [0:LOG_DEPTH-1];

    sram_uart_tx_interface #(.BAUD_DIVIDER(BAUD)) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_start          (start),
        .i_base_address   (baseAddress),
        .i_word_count     (wordCount),
        .o_sram_address   (sramAddress),
        .i_sram_read_data (sramReadData),
        .o_sram_we_n      (sramWeN),
        .o_uart_tx        (uartTx),
        .o_busy           (busy),
        .o_done           (done)
    );

    always #5 clock = ~clock;

    // SRAM read data appears two clock edges after the address is registered
    always @(posedge clock) begin
        sramPipe1 <= sramMem[sramAddress];
        sramPipe2 <= sramPipe1;
    end
    assign sramReadData = sramPipe2;

    // Start is accepted on the posedge this task waits for; inputs are scrambled afterwards
    task automatic applyStimulus(input logic [17:0] base, input logic [17:0] count);
        @(negedge clock);
        baseAddress = base;
        wordCount   = count;
        start       = 1'b1;
        @(posedge clock);
        #1;
        start       = 1'b0;
        baseAddress = 18'($urandom);
        wordCount   = 18'($urandom);
    endtask

    // Index i holds the values seen just after the (i+1)-th edge following acceptance
    task automatic captureLine(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            lineLog[i] = uartTx;
            doneLog[i] = done;
            busyLog[i] = busy;
            addrLog[i] = sramAddress;
        end
    endtask

    function automatic int byteErrors(input int firstIdx, input logic [7:0] value);
        logic [9:0] frame;
        int errs;
        frame = {1'b1, value, 1'b0};
        errs = 0;
        for (int c = 0; c < 10 * BAUD; c++) begin
            if (lineLog[firstIdx + c] !== frame[c / BAUD]) errs++;
        end
        return errs;
    endfunction

    function automatic int countDone(input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) if (doneLog[i] === 1'b1) cnt++;
        return cnt;
    endfunction

    function automatic int countOverlap(input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n; i++) if (doneLog[i] === 1'b1 && busyLog[i] === 1'b1) cnt++;
        return cnt;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        testsRun++;
        if (uartTx !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tx: got %b expected 1", uartTx); end
        testsRun++;
        if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        testsRun++;
        if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        testsRun++;
        if (sramAddress !== 18'd0) begin testsFailed++; $display("[TB] FAIL reset_addr: got %h expected 0", sramAddress); end
        testsRun++;
        if (sramWeN !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_we_n: got %b expected 1", sramWeN); end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_single_word();
        int errs;
        applyStimulus(18'h100, 18'd1);
        testsRun++;
        if (busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_busy_rise: got %b expected 1", busy); end
        captureLine(90);
        testsRun++;
        if ({lineLog[0], lineLog[1], lineLog[2]} !== 3'b110) begin
            testsFailed++;
            $display("[TB] FAIL single_fall_time: got %b%b%b expected 110", lineLog[0], lineLog[1], lineLog[2]);
        end
        errs = byteErrors(2, 8'hA5);
        testsRun++;
        if (errs !== 0) begin testsFailed++; $display("[TB] FAIL single_byte_hi: got %0d bad cycles expected 0", errs); end
        errs = byteErrors(42, 8'h5A);
        testsRun++;
        if (errs !== 0) begin testsFailed++; $display("[TB] FAIL single_byte_lo: got %0d bad cycles expected 0", errs); end
        testsRun++;
        if (doneLog[82] !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_done_time: got %b expected 1", doneLog[82]); end
        testsRun++;
        if (countDone(90) !== 1) begin testsFailed++; $display("[TB] FAIL single_done_count: got %0d expected 1", countDone(90)); end
        testsRun++;
        if (busyLog[82] !== 1'b0 || busyLog[81] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL single_busy_fall: got %b%b expected 10", busyLog[81], busyLog[82]);
        end
        testsRun++;
        if (lineLog[82] !== 1'b1) begin testsFailed++; $display("[TB] FAIL single_idle_after: got %b expected 1", lineLog[82]); end
        testsRun++;
        if (addrLog[81] !== 18'h100) begin testsFailed++; $display("[TB] FAIL single_addr: got %h expected 100", addrLog[81]); end
        testsRun++;
        if (countOverlap(90) !== 0) begin testsFailed++; $display("[TB] FAIL single_overlap: got %0d expected 0", countOverlap(90)); end
    endtask

    task automatic test_zero_count();
        int highs;
        int addrOk;
        applyStimulus(18'h155, 18'd0);
        testsRun++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL zero_done_pulse: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        testsRun++;
        if (sramAddress !== 18'h100) begin testsFailed++; $display("[TB] FAIL zero_addr_now: got %h expected 100", sramAddress); end
        captureLine(20);
        highs = 0;
        addrOk = 0;
        for (int i = 0; i < 20; i++) begin
            if (lineLog[i] === 1'b1) highs++;
            if (addrLog[i] === 18'h100) addrOk++;
        end
        testsRun++;
        if (countDone(20) !== 0) begin testsFailed++; $display("[TB] FAIL zero_done_once: got %0d extra expected 0", countDone(20)); end
        testsRun++;
        if (highs !== 20) begin testsFailed++; $display("[TB] FAIL zero_line_idle: got %0d high cycles expected 20", highs); end
        testsRun++;
        if (addrOk !== 20) begin testsFailed++; $display("[TB] FAIL zero_addr_held: got %0d ok cycles expected 20", addrOk); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] expBytes [0:5];
        int errs;
        expBytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        applyStimulus(18'h200, 18'd3);
        captureLine(250);
        for (int b = 0; b < 6; b++) begin
            errs = byteErrors(2 + 40 * b, expBytes[b]);
            testsRun++;
            if (errs !== 0) begin testsFailed++; $display("[TB] FAIL b2b_byte%0d: got %0d bad cycles expected 0", b, errs); end
        end
        testsRun++;
        if (lineLog[1] !== 1'b1 || lineLog[242] !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_span: got pre=%b post=%b expected 1 1", lineLog[1], lineLog[242]);
        end
        testsRun++;
        if (doneLog[242] !== 1'b1 || countDone(250) !== 1) begin
            testsFailed++;
            $display("[TB] FAIL b2b_done: got at242=%b count=%0d expected 1 1", doneLog[242], countDone(250));
        end
        testsRun++;
        if (addrLog[41] !== 18'h200 || addrLog[42] !== 18'h201 || addrLog[121] !== 18'h201 ||
            addrLog[122] !== 18'h202 || addrLog[241] !== 18'h202) begin
            testsFailed++;
            $display("[TB] FAIL b2b_addr: got %h %h %h %h %h expected 200 201 201 202 202",
                     addrLog[41], addrLog[42], addrLog[121], addrLog[122], addrLog[241]);
        end
        testsRun++;
        if (countOverlap(250) !== 0) begin testsFailed++; $display("[TB] FAIL b2b_overlap: got %0d expected 0", countOverlap(250)); end
    endtask

    task automatic test_address_wrap();
        logic [7:0] expBytes [0:3];
        int errs;
        expBytes = '{8'h12, 8'h34, 8'hC3, 8'h3C};
        applyStimulus(18'h3FFFF, 18'd2);
        captureLine(170);
        for (int b = 0; b < 4; b++) begin
            errs = byteErrors(2 + 40 * b, expBytes[b]);
            testsRun++;
            if (errs !== 0) begin testsFailed++; $display("[TB] FAIL wrap_byte%0d: got %0d bad cycles expected 0", b, errs); end
        end
        testsRun++;
        if (addrLog[41] !== 18'h3FFFF || addrLog[42] !== 18'h0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_addr: got %h %h expected 3ffff 0", addrLog[41], addrLog[42]);
        end
        testsRun++;
        if (doneLog[162] !== 1'b1) begin testsFailed++; $display("[TB] FAIL wrap_done: got %b expected 1", doneLog[162]); end
    endtask

    task automatic test_start_while_busy();
        int errs;
        int highs;
        applyStimulus(18'h300, 18'd1);
        fork
            captureLine(130);
            begin
                repeat (20) @(negedge clock);
                baseAddress = 18'h200;
                wordCount   = 18'd3;
                start       = 1'b1;
                @(negedge clock);
                start       = 1'b0;
            end
        join
        errs = byteErrors(2, 8'h6E) + byteErrors(42, 8'h91);
        testsRun++;
        if (errs !== 0) begin testsFailed++; $display("[TB] FAIL busy_ignore_bytes: got %0d bad cycles expected 0", errs); end
        testsRun++;
        if (doneLog[82] !== 1'b1 || countDone(130) !== 1) begin
            testsFailed++;
            $display("[TB] FAIL busy_ignore_done: got at82=%b count=%0d expected 1 1", doneLog[82], countDone(130));
        end
        highs = 0;
        for (int i = 83; i < 130; i++) if (lineLog[i] === 1'b1) highs++;
        testsRun++;
        if (highs !== 47) begin testsFailed++; $display("[TB] FAIL busy_ignore_idle: got %0d high cycles expected 47", highs); end
        testsRun++;
        if (addrLog[129] !== 18'h300) begin testsFailed++; $display("[TB] FAIL busy_ignore_addr: got %h expected 300", addrLog[129]); end
        testsRun++;
        if (countOverlap(130) !== 0) begin testsFailed++; $display("[TB] FAIL busy_ignore_overlap: got %0d expected 0", countOverlap(130)); end
    endtask

    task automatic test_reset_mid_byte();
        int errs;
        applyStimulus(18'h180, 18'd1);
        captureLine(58);
        errs = byteErrors(2, 8'h3C);
        testsRun++;
        if (errs !== 0) begin testsFailed++; $display("[TB] FAIL midrst_byte_hi: got %0d bad cycles expected 0", errs); end
        @(posedge clock);
        #2;
        testsRun++;
        if (uartTx !== 1'b0 || busy !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_pre: got tx=%b busy=%b expected tx=0 busy=1", uartTx, busy);
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (uartTx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midrst_async: got tx=%b busy=%b done=%b expected 1 0 0", uartTx, busy, done);
        end
        testsRun++;
        if (sramAddress !== 18'd0) begin testsFailed++; $display("[TB] FAIL midrst_addr: got %h expected 0", sramAddress); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(18'h200, 18'd1);
        captureLine(90);
        errs = byteErrors(2, 8'h01) + byteErrors(42, 8'h02);
        testsRun++;
        if (errs !== 0) begin testsFailed++; $display("[TB] FAIL midrst_restart_bytes: got %0d bad cycles expected 0", errs); end
        testsRun++;
        if (doneLog[82] !== 1'b1 || countDone(90) !== 1) begin
            testsFailed++;
            $display("[TB] FAIL midrst_restart_done: got at82=%b count=%0d expected 1 1", doneLog[82], countDone(90));
        end
    endtask

    initial begin
        sramMem[18'h100]   = 16'hA55A;
        sramMem[18'h180]   = 16'h3CF0;
        sramMem[18'h200]   = 16'h0102;
        sramMem[18'h201]   = 16'h0304;
        sramMem[18'h202]   = 16'h0506;
        sramMem[18'h300]   = 16'h6E91;
        sramMem[18'h3FFFF] = 16'h1234;
        sramMem[18'h0]     = 16'hC33C;

        test_reset();
        test_single_word();
        test_zero_count();
        test_back_to_back();
        test_address_wrap();
        test_start_while_busy();
        test_reset_mid_byte();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
